// File: rtl/clock_hm_counter.sv
// Hours/minutes BCD time-of-day counter with a RUN / SET_MIN / SET_HOUR mode
// machine driven by debounced mode and increment button pulses.
module clock_hm_counter #(
    parameter int p_hour_limit = 24
) (
    input  logic       i_clock_50mhz,
    input  logic       i_reset,
    input  logic       i_minute_imp,
    input  logic       i_mode_btn,
    input  logic       i_inc_btn,
    output logic [3:0] o_val_lmin,
    output logic [2:0] o_val_hmin,
    output logic [3:0] o_val_lhour,
    output logic [1:0] o_val_hhour,
    output logic       o_hour_imp,
    output logic       o_day_imp,
    output logic [1:0] o_state,
    output logic       o_sync_clear
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_MIN  = 2'd1,
        ST_SET_HOUR = 2'd2,
        ST_BAD      = 2'd3
    } state_e;

    localparam logic [1:0] HH_MAX = 2'((p_hour_limit - 1) / 10);
    localparam logic [3:0] LH_MAX = 4'((p_hour_limit - 1) % 10);

    state_e     state_d;
    logic [1:0] state_q;
    logic [3:0] lmin_q, lmin_d, lhour_q, lhour_d;
    logic [2:0] hmin_q, hmin_d;
    logic [1:0] hhour_q, hhour_d;
    logic       hour_imp_q, hour_imp_d;
    logic       day_imp_q, day_imp_d;
    logic       sync_clear_q, sync_clear_d;

    logic [3:0] lmin_inc, lhour_inc;
    logic [2:0] hmin_inc;
    logic [1:0] hhour_inc;
    logic       min_carry, hour_top;

    // Incremented candidates; >= compares keep any odd value falling back into range.
    always_comb begin
        min_carry = 1'b0;
        lmin_inc  = lmin_q + 4'd1;
        hmin_inc  = hmin_q;
        if (lmin_q >= 4'd9) begin
            lmin_inc = 4'd0;
            if (hmin_q >= 3'd5) begin
                hmin_inc  = 3'd0;
                min_carry = 1'b1;
            end else begin
                hmin_inc = hmin_q + 3'd1;
            end
        end

        hour_top  = (hhour_q > HH_MAX) || ((hhour_q == HH_MAX) && (lhour_q >= LH_MAX));
        lhour_inc = lhour_q + 4'd1;
        hhour_inc = hhour_q;
        if (hour_top) begin
            lhour_inc = 4'd0;
            hhour_inc = 2'd0;
        end else if (lhour_q >= 4'd9) begin
            lhour_inc = 4'd0;
            hhour_inc = hhour_q + 2'd1;
        end
    end

    always_comb begin
        state_d      = state_e'(state_q);
        lmin_d       = lmin_q;
        hmin_d       = hmin_q;
        lhour_d      = lhour_q;
        hhour_d      = hhour_q;
        hour_imp_d   = 1'b0;
        day_imp_d    = 1'b0;
        sync_clear_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Minute pulse and mode press in the same cycle both take effect.
                if (i_minute_imp) begin
                    lmin_d = lmin_inc;
                    hmin_d = hmin_inc;
                    if (min_carry) begin
                        lhour_d    = lhour_inc;
                        hhour_d    = hhour_inc;
                        hour_imp_d = 1'b1;
                        day_imp_d  = hour_top;
                    end
                end
                if (i_mode_btn) state_d = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                if (i_mode_btn) begin
                    state_d = ST_SET_HOUR;
                end else if (i_inc_btn) begin
                    lmin_d = lmin_inc;
                    hmin_d = hmin_inc;
                end
            end
            ST_SET_HOUR: begin
                if (i_mode_btn) begin
                    state_d      = ST_RUN;
                    sync_clear_d = 1'b1;
                end else if (i_inc_btn) begin
                    lhour_d = lhour_inc;
                    hhour_d = hhour_inc;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clock_50mhz) begin
        if (i_reset) begin
            state_q      <= ST_RUN;
            lmin_q       <= 4'd0;
            hmin_q       <= 3'd0;
            lhour_q      <= 4'd0;
            hhour_q      <= 2'd0;
            hour_imp_q   <= 1'b0;
            day_imp_q    <= 1'b0;
            sync_clear_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lmin_q       <= lmin_d;
            hmin_q       <= hmin_d;
            lhour_q      <= lhour_d;
            hhour_q      <= hhour_d;
            hour_imp_q   <= hour_imp_d;
            day_imp_q    <= day_imp_d;
            sync_clear_q <= sync_clear_d;
        end
    end

    assign o_val_lmin   = lmin_q;
    assign o_val_hmin   = hmin_q;
    assign o_val_lhour  = lhour_q;
    assign o_val_hhour  = hhour_q;
    assign o_hour_imp   = hour_imp_q;
    assign o_day_imp    = day_imp_q;
    assign o_state      = state_q;
    assign o_sync_clear = sync_clear_q;

endmodule

// File: tb/tb_clock_hm_counter.sv
// Directed bench for clock_hm_counter: a 24-hour and a 12-hour instance share
// all inputs; time is compared as a decimal hhmm number.
module tb_clock_hm_counter;

    logic clk = 1'b0;
    logic rst, mi, mo, ib;

    logic [3:0] a_lmin, a_lhour, b_lmin, b_lhour;
    logic [2:0] a_hmin, b_hmin;
    logic [1:0] a_hhour, b_hhour, a_state, b_state;
    logic       a_himp, a_dimp, a_sync, b_himp, b_dimp, b_sync;

    int total = 0;
    int bad   = 0;
    int hcnt  = 0;
    int dcnt  = 0;

    always #10 clk = ~clk;

    clock_hm_counter #(.p_hour_limit(24)) u24 (
        .i_clock_50mhz(clk), .i_reset(rst), .i_minute_imp(mi), .i_mode_btn(mo), .i_inc_btn(ib),
        .o_val_lmin(a_lmin), .o_val_hmin(a_hmin), .o_val_lhour(a_lhour), .o_val_hhour(a_hhour),
        .o_hour_imp(a_himp), .o_day_imp(a_dimp), .o_state(a_state), .o_sync_clear(a_sync)
    );

    clock_hm_counter #(.p_hour_limit(12)) u12 (
        .i_clock_50mhz(clk), .i_reset(rst), .i_minute_imp(mi), .i_mode_btn(mo), .i_inc_btn(ib),
        .o_val_lmin(b_lmin), .o_val_hmin(b_hmin), .o_val_lhour(b_lhour), .o_val_hhour(b_hhour),
        .o_hour_imp(b_himp), .o_day_imp(b_dimp), .o_state(b_state), .o_sync_clear(b_sync)
    );

    function automatic int t24();
        return int'(a_hhour) * 1000 + int'(a_lhour) * 100 + int'(a_hmin) * 10 + int'(a_lmin);
    endfunction

    function automatic int t12();
        return int'(b_hhour) * 1000 + int'(b_lhour) * 100 + int'(b_hmin) * 10 + int'(b_lmin);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge; returns on the next negedge with outputs settled.
    task automatic cycle(input logic r, input logic m, input logic md, input logic ic);
        rst = r; mi = m; mo = md; ib = ic;
        @(negedge clk);
        rst = 1'b0; mi = 1'b0; mo = 1'b0; ib = 1'b0;
        hcnt += int'(a_himp);
        dcnt += int'(a_dimp);
    endtask

    task automatic run_min(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        hcnt = 0;
        dcnt = 0;
    endtask

    initial begin
        rst = 1'b1; mi = 1'b0; mo = 1'b0; ib = 1'b0;
        @(negedge clk);

        // Reset with other inputs active
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_time", t24(), 0);
        check("rst_state", int'(a_state), 0);
        check("rst_imps", int'({a_himp, a_dimp, a_sync}), 0);
        hcnt = 0; dcnt = 0;

        // Carry chain through the first hour
        run_min(1);
        check("first_min", t24(), 1);
        run_min(9);
        check("min_tens_carry", t24(), 10);
        run_min(49);
        check("min_59", t24(), 59);
        check("no_himp_yet", hcnt, 0);
        run_min(1);
        check("hour_carry", t24(), 100);
        check("himp_pulse", int'(a_himp), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("himp_one_cycle", int'(a_himp), 0);
        check("himp_count", hcnt, 1);
        check("dimp_count", dcnt, 0);

        // Set mode: minute wrap without carry, hour wrap without impulse
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("st_set_min", int'(a_state), 1);
        check("no_sync_run_to_min", int'(a_sync), 0);
        incs(61);
        check("set_min_x61", t24(), 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("st_set_hour", int'(a_state), 2);
        incs(25);
        check("set_hour_x25_24", t24(), 101);
        check("set_hour_x25_12", t12(), 101);
        check("set_no_imps", hcnt + dcnt, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("st_back_run", int'(a_state), 0);
        check("sync_pulse", int'(a_sync), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("sync_one_cycle", int'(a_sync), 0);

        // Freeze and mode/inc conflict
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        run_min(3);
        check("freeze_set_min", t24(), 101);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("mode_wins_state", int'(a_state), 2);
        check("mode_wins_time", t24(), 101);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Day wrap on both instances: 23 hour increments give 23 and 11
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        incs(59);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        incs(10);
        check("hour_units_carry_24", t24(), 1059);
        check("hour_units_carry_12", t12(), 1059);
        incs(13);
        check("set_2359", t24(), 2359);
        check("set_1159", t12(), 1159);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        run_min(1);
        check("day_wrap_24", t24(), 0);
        check("day_wrap_12", t12(), 0);
        check("day_imps_24", int'({a_himp, a_dimp}), 3);
        check("day_imps_12", int'({b_himp, b_dimp}), 3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("day_imp_one_cycle", int'({a_himp, a_dimp, b_himp, b_dimp}), 0);

        // Mode press together with minute carry in RUN
        do_reset();
        run_min(59);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("conflict_time", t24(), 100);
        check("conflict_imps", int'({a_himp, a_dimp}), 2);
        check("conflict_state", int'(a_state), 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the carry cycle and in a SET state
        do_reset();
        run_min(59);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_carry_time", t24(), 0);
        check("rst_carry_himp", int'(a_himp), 0);
        check("rst_carry_state", int'(a_state), 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_in_set_state", int'(a_state), 0);

        // Illegal state encoding recovers to RUN, time preserved
        do_reset();
        run_min(5);
        force u24.state_q = 2'd3;
        #1;
        release u24.state_q;
        @(negedge clk);
        check("bad_state_recover", int'(a_state), 0);
        check("bad_state_time", t24(), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_hm_counter.md
CLOCK_HM_COUNTER -- requirements
Module: clock_hm_counter

Interface
REQ-001 The module SHALL have parameter p_hour_limit, default 24, which is the hour count modulus; legal values are 12 and 24, and hours count 0..p_hour_limit-1.
REQ-002 i_clock_50mhz  in  1  single system clock; all logic is rising-edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_minute_imp  in  1  one-cycle minute pulse from the seconds stage.
REQ-005 i_mode_btn  in  1  one-cycle pulse from a debounced button that advances the mode.
REQ-006 i_inc_btn  in  1  one-cycle pulse from a debounced button that increments the field being set.
REQ-007 o_val_lmin  out  4  minutes units digit in BCD, 0..9.
REQ-008 o_val_hmin  out  3  minutes tens digit in BCD, 0..5.
REQ-009 o_val_lhour  out  4  hours units digit in BCD, 0..9.
REQ-010 o_val_hhour  out  2  hours tens digit in BCD, 0..2.
REQ-011 o_hour_imp  out  1  one-cycle pulse on the minutes 59->00 carry.
REQ-012 o_day_imp  out  1  one-cycle pulse on the full time wrap to 00:00.
REQ-013 o_state  out  2  current mode: RUN=0, SET_MIN=1, SET_HOUR=2.
REQ-014 o_sync_clear  out  1  one-cycle pulse on SET_HOUR->RUN; upstream uses it to restart the seconds count.

Function
REQ-015 All outputs SHALL be registered; each update SHALL appear one clock after the triggering input is sampled high.
REQ-016 In RUN, each i_minute_imp SHALL increment the time by one minute, with these rules:
- units 9->0 carries to tens;
- minutes 59->00 carries to hours.
REQ-017 Hours SHALL increment as a BCD pair: units 9->0 carries to tens.
REQ-018 At hour value p_hour_limit-1, a carry from minutes SHALL wrap the hours to 00.
REQ-019 o_hour_imp SHALL assert for exactly the one cycle in which the minutes read 00 after a carry.
REQ-020 o_day_imp SHALL assert in the same cycle as o_hour_imp when the time wraps to 00:00; it is asserted in no other case.
REQ-021 The state machine SHALL advance on i_mode_btn as RUN->SET_MIN->SET_HOUR->RUN.
REQ-022 Encoding 3 SHALL return to RUN on the next clock.
REQ-023 In SET_MIN and SET_HOUR, i_minute_imp SHALL be ignored and the time frozen; pulses are dropped, not queued.
REQ-024 In SET_MIN, i_inc_btn SHALL increment the minutes with wrap 59->00; there is no hour carry and no impulse output.
REQ-025 In SET_HOUR, i_inc_btn SHALL increment the hours with wrap p_hour_limit-1->00; there is no o_day_imp.
REQ-026 In RUN, i_inc_btn SHALL be ignored.
REQ-027 When i_mode_btn and i_inc_btn are high in the same cycle, the mode change SHALL win and i_inc_btn SHALL be discarded.
REQ-028 When i_mode_btn and i_minute_imp are high in the same cycle while in RUN, both SHALL take effect: the time increments (including any impulses) and the state becomes SET_MIN.
REQ-029 o_sync_clear SHALL pulse for one cycle coincident with o_state returning to 0 from SET_HOUR; it SHALL not pulse on any other transition.
REQ-030 Digit registers SHALL never hold a non-BCD or out-of-range value, whatever the input sequence.

Reset
REQ-031 While i_reset is high, all of the following SHALL hold on the next clock edge and stay held until release, with all other inputs ignored:
- all digit outputs = 0;
- o_state = RUN;
- o_hour_imp = 0, o_day_imp = 0, o_sync_clear = 0.
REQ-032 Reset asserted mid-operation, including in a SET state or in the cycle of a carry, SHALL override all other activity: no impulse SHALL be emitted in the cycle following the reset edge.
REQ-033 The first i_minute_imp after reset release SHALL yield time 00:01.

Verification
REQ-034 Carry chain: from reset, apply 60 i_minute_imp pulses -> time 01:00, exactly one o_hour_imp, o_day_imp stays 0.
REQ-035 Day wrap (p_hour_limit=24): set 23:59, return to RUN, apply one i_minute_imp -> 00:00 with o_hour_imp=o_day_imp=1 for one cycle. Repeat with p_hour_limit=12: 11:59 -> 00:00.
REQ-036 Set mode: pulse mode, then inc x61 -> minutes 01 and hours unchanged; pulse mode, then inc x25 -> hours 01 with no impulses; pulse mode -> o_state=0 and o_sync_clear for one cycle.
REQ-037 Freeze and conflict checks:
- i_minute_imp pulses during SET_MIN -> time unchanged.
- i_mode_btn together with i_inc_btn in SET_MIN -> state SET_HOUR, minutes unchanged.
- i_mode_btn together with i_minute_imp in RUN at 00:59 -> 01:00, o_hour_imp, state SET_MIN.
REQ-038 Reset in the carry cycle: assert i_reset together with i_minute_imp at 00:59 -> 00:00, state RUN, no o_hour_imp.
REQ-039 Illegal state: force o_state encoding 3 -> RUN one clock later, time preserved.
